// File: rtl/pwl_activation_pipe.sv
// Pipelined piecewise-linear activation: translate, table read, interpolate.
// Define PWL_ROUND_EN for round-half-up interpolation instead of floor.
module pwl_activation_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24,
    parameter int MODES  = 2,
    localparam int ADDR_W = DATA_W - FRAC_W,
    localparam int BANK_W = (MODES > 1) ? $clog2(MODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic [BANK_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    input  logic              tbl_we,
    input  logic [BANK_W-1:0] tbl_bank,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = DATA_W + FRAC_W + 2;

    localparam logic [BANK_W:0]   MODES_V  = (BANK_W + 1)'(MODES);
    localparam logic [ADDR_W-1:0] ADDR_TOP = {1'b0, {(ADDR_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] HALF =
        {{(PW - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
        logic [FRAC_W-1:0] rem;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] next;
        logic [FRAC_W-1:0] rem;
    } s2_t;

    logic [DATA_W-1:0] mem [MODES*DEPTH];

    s1_t s1_q;
    s2_t s2_q;

    logic              stall;
    logic [BANK_W-1:0] in_bank;
    logic [ADDR_W-1:0] nxt_addr;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_adj;
    logic [DATA_W-1:0]      slope_term;
    logic [DATA_W-1:0]      a_next;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Unknown modes fall back to the first bank.
    assign in_bank = ({1'b0, in_mode} < MODES_V) ? in_mode : '0;

    // The most positive segment has no right neighbour: hold it flat.
    assign nxt_addr = (s1_q.addr == ADDR_TOP) ? s1_q.addr : s1_q.addr + 1'b1;

    always_ff @(posedge clk) begin
        if (tbl_we && ({1'b0, tbl_bank} < MODES_V)) begin
            mem[{tbl_bank, tbl_addr}] <= tbl_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (!stall) begin
            s1_q.valid <= in_valid;
            s1_q.bank  <= in_bank;
            s1_q.addr  <= in_z[DATA_W-1:FRAC_W];
            s1_q.rem   <= in_z[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_q <= '0;
        end else if (!stall) begin
            s2_q.valid <= s1_q.valid;
            s2_q.base  <= mem[{s1_q.bank, s1_q.addr}];
            s2_q.next  <= mem[{s1_q.bank, nxt_addr}];
            s2_q.rem   <= s1_q.rem;
        end
    end

    always_comb begin
        diff = $signed({s2_q.next[DATA_W-1], s2_q.next})
             - $signed({s2_q.base[DATA_W-1], s2_q.base});
        prod = PW'(diff) * PW'($signed({1'b0, s2_q.rem}));
`ifdef PWL_ROUND_EN
        prod_adj = prod + HALF;
`else
        prod_adj = prod;
`endif
        slope_term = DATA_W'(prod_adj >>> FRAC_W);
        a_next     = s2_q.base + slope_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
        end else if (!stall) begin
            out_valid <= s2_q.valid;
            out_a     <= a_next;
        end
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Directed bench for pwl_activation_pipe: vector table plus stream,
// reset and table-write sequences.
module tb_pwl_activation_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_z = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a;
    logic        tbl_we = 1'b0;
    logic [1:0]  tbl_bank = '0;
    logic [7:0]  tbl_addr = '0;
    logic [31:0] tbl_data = '0;

    always #5 clk = ~clk;

    pwl_activation_pipe #(
        .DATA_W(32),
        .FRAC_W(24),
        .MODES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_z     (in_z),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .tbl_we   (tbl_we),
        .tbl_bank (tbl_bank),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data)
    );

`ifdef PWL_ROUND_EN
    localparam logic [31:0] E_RND  = 32'd2;
    localparam logic [31:0] E_NRND = 32'd2;
    localparam logic [31:0] E_WRAP = 32'h0000_0000;
`else
    localparam logic [31:0] E_RND  = 32'd1;
    localparam logic [31:0] E_NRND = 32'd1;
    localparam logic [31:0] E_WRAP = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] z;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];
    vec_t strm[8];
    logic [31:0] expq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tbl_write(input logic [1:0] b, input logic [7:0] a,
                             input logic [31:0] d);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_bank = b;
        tbl_addr = a;
        tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [1:0] m,
                           input logic [31:0] z, input logic [31:0] exp);
        int lat = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_mode   = m;
        in_z      = z;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no result within 10 cycles, expected %h", name, exp);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'd3);
            check(name, out_a, exp);
        end
    endtask

    task automatic collect(input string name);
        int guard = 0;
        while (expq.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (out_valid) check(name, out_a, expq.pop_front());
        end
        if (expq.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d results missing, expected %0d more",
                     name, expq.size(), expq.size());
            expq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int stall_cycles;

        vecs[0]  = '{2'd0, 32'h0080_0000, 32'h0040_0000};
        vecs[1]  = '{2'd0, 32'hFF80_0000, 32'hFFC0_0000};
        vecs[2]  = '{2'd0, 32'h7FFF_FFFF, 32'h00FF_0000};
        vecs[3]  = '{2'd0, 32'h0100_0000, 32'h0080_0000};
        vecs[4]  = '{2'd0, 32'h01C0_0000, 32'h0020_0000};
        vecs[5]  = '{2'd1, 32'h0080_0000, E_RND};
        vecs[6]  = '{2'd1, 32'h0180_0000, E_NRND};
        vecs[7]  = '{2'd1, 32'h0340_0000, 32'h0014_0000};
        vecs[8]  = '{2'd2, 32'h0100_0000, 32'h0AAA_AAAA};
        vecs[9]  = '{2'd3, 32'h0100_0000, 32'h0080_0000};
        vecs[10] = '{2'd1, 32'h0680_0000, E_WRAP};

        strm[0] = '{2'd0, 32'h0080_0000, 32'h0040_0000};
        strm[1] = '{2'd1, 32'h0340_0000, 32'h0014_0000};
        strm[2] = '{2'd0, 32'hFF80_0000, 32'hFFC0_0000};
        strm[3] = '{2'd1, 32'h0100_0000, 32'h0000_0003};
        strm[4] = '{2'd0, 32'h7FFF_FFFF, 32'h00FF_0000};
        strm[5] = '{2'd1, 32'h0400_0000, 32'h0020_0000};
        strm[6] = '{2'd0, 32'h0100_0000, 32'h0080_0000};
        strm[7] = '{2'd1, 32'h0300_0000, 32'h0010_0000};

        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_a", out_a, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        tbl_write(2'd0, 8'd0,   32'h0000_0000);
        tbl_write(2'd0, 8'd1,   32'h0080_0000);
        tbl_write(2'd0, 8'd2,   32'h0000_0000);
        tbl_write(2'd0, 8'd127, 32'h00FF_0000);
        tbl_write(2'd0, 8'd128, 32'h1234_5678);
        tbl_write(2'd0, 8'd255, 32'hFF80_0000);
        tbl_write(2'd1, 8'd0,   32'h0000_0000);
        tbl_write(2'd1, 8'd1,   32'h0000_0003);
        tbl_write(2'd1, 8'd2,   32'h0000_0000);
        tbl_write(2'd1, 8'd3,   32'h0010_0000);
        tbl_write(2'd1, 8'd4,   32'h0020_0000);
        tbl_write(2'd1, 8'd5,   32'h0030_0000);
        tbl_write(2'd1, 8'd6,   32'h7FFF_FFFF);
        tbl_write(2'd1, 8'd7,   32'h8000_0000);
        tbl_write(2'd2, 8'd1,   32'h0AAA_AAAA);
        tbl_write(2'd2, 8'd2,   32'h0AAA_AAAA);
        tbl_write(2'd3, 8'd1,   32'hDEAD_BEEF);

        for (int i = 0; i < 11; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].mode, vecs[i].z, vecs[i].exp);
        end

        sent = 0;
        recv = 0;
        stall_cycles = 0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 8);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_mode  = strm[sent].mode;
                in_z     = strm[sent].z;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && out_valid && recv < 8) begin
                stall_cycles++;
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                check("stall_hold", out_a, strm[recv].exp);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (recv < 8) begin
                    check($sformatf("stream%0d", recv), out_a, strm[recv].exp);
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stream_extra: got %h, expected no result", out_a);
                end
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'd8);
        check("stall_cycles", 32'(stall_cycles), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stream_no_dup", {31'b0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mode  = 2'd0;
            in_z     = 32'h0080_0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_flush", {31'b0, out_valid}, 32'd0);
        end

        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_z     = 32'h0000_0000;
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_bank = 2'd0;
        tbl_addr = 8'd0;
        tbl_data = 32'h00AB_CDEF;
        @(negedge clk);
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        expq.push_back(32'h0000_0000);
        expq.push_back(32'h00AB_CDEF);
        collect("write_hazard");

        tbl_write(2'd0, 8'd0, 32'h1234_5678);
        run_one("clamp_t0", 2'd0, 32'h7FFF_FFFF, 32'h00FF_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwl_activation_pipe.md
Name: pwl_activation_pipe

Overview:
- Pipelined, parametrised piecewise-linear activation unit in signed fixed point; successor to the combinational single-function tanh translator/table/calculator chain.
- Supports MODES runtime-loadable function banks (e.g. bank 0 tanh, bank 1 sigmoid) selected per sample.
- Uses valid/ready handshakes on both sides and sits between a neuron accumulator and the next layer's input buffer.
- Throughput is one sample per cycle, with 3-cycle latency.

Parameters:
- DATA_W, 32, total signed data width (input z, table entries, output a).
- FRAC_W, 24, fractional bits. ADDR_W = DATA_W-FRAC_W is derived (8 by default) and is the table index width.
- MODES, 2, number of function banks. BANK_W = max(1, clog2(MODES)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit accepts a sample this cycle.
- in_z  in  DATA_W  signed input value.
- in_mode  in  BANK_W  function bank for this sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_a  out  DATA_W  signed activation result.
- tbl_we  in  1  table write strobe.
- tbl_bank  in  BANK_W  bank being written.
- tbl_addr  in  ADDR_W  entry index being written.
- tbl_data  in  DATA_W  entry value.

Behaviour:
- Clocking and reset: single clock domain; clk and rst only, rst asynchronous active-high.
- Reset values: out_valid=0, out_a=0, all stage-valid flags 0. Table contents are not reset.
- Reset mid-operation: in-flight samples are discarded and nothing is emitted for them.
- Handshake:
  - A transfer occurs when valid&&ready.
  - Global stall when out_valid && !out_ready; then all stages hold.
  - in_ready = !(out_valid && !out_ready), purely combinational from registered state and out_ready.
  - out_a and out_valid must stay stable while stalled.
- Stage 1 (capture/translate):
  - Register z and mode.
  - addr = z[DATA_W-1:FRAC_W] (raw two's-complement integer field); rem = z[FRAC_W-1:0] (unsigned).
- Stage 2 (table):
  - Synchronous read of base = T[mode][addr] and next = T[mode][addr+1 mod 2^ADDR_W].
  - Exception: when addr == 2^(ADDR_W-1)-1 (most positive), next = base (saturating clamp).
  - addr = all-ones (-1) wraps to 0, which is the intended continuous behaviour.
- Stage 3 (interpolate):
  - diff = next - base, computed at DATA_W+1 bits signed.
  - prod = diff * {0,rem}, signed full width.
  - a = base + (prod >>> FRAC_W), truncated to DATA_W (wraps, no saturation). Registered into out_a.
- Latency: a sample accepted in cycle N appears on out_a/out_valid in cycle N+3 when there are no stalls.
- Table write port:
  - Write is permitted at any time, including while stalled.
  - A write in cycle N is visible to stage-2 reads from cycle N+1.
  - A same-cycle read of the written entry returns old data.
  - tbl_bank >= MODES: the write is ignored.
- in_mode >= MODES: treated as bank 0.
- Storage: MODES*2^ADDR_W entries, with two read ports and one write port.

Optional Feature:
- Macro: PWL_ROUND_EN.
- Defined: stage 3 uses round-half-up, a = base + ((prod + 2^(FRAC_W-1)) >>> FRAC_W).
- Undefined: truncation (floor) as above. Latency and handshake are unchanged in both cases.

Test Plan:
- Basic interpolation:
  - Load bank0 T[0]=0x00000000, T[1]=0x00800000; drive z=0x00800000, mode=0.
  - Expect out_a=0x00400000 exactly 3 cycles after acceptance.
- Negative wrap:
  - Load T[255]=0xFF800000, T[0]=0; drive z=0xFF800000.
  - Expect out_a=0xFFC00000.
- Clamp:
  - Load T[127]=0x00FF0000, T[0]=0x12345678; drive z=0x7FFFFFFF.
  - Expect out_a=0x00FF0000 (next forced equal to base).
- Stream with backpressure and bank switching:
  - Send 8 back-to-back samples alternating mode 0/1; hold out_ready=0 for 4 cycles mid-stream.
  - Expect in_ready=0 during the stall, no loss or duplication, results in order, out_a stable while stalled.
- Rounding:
  - Load T[0]=0, T[1]=3; drive z=0x00800000.
  - Expect out_a=1 without PWL_ROUND_EN and 2 with it.
- Reset and write hazard:
  - Assert rst with 3 samples in flight; expect out_valid=0 immediately and no later output for them.
  - Separately, write T[0] in the same cycle a sample reads it; expect the old value used, and the new value used by the next sample.
